// File: rtl/shake_sched_pkg.sv
// Shared types and constants for the SHAKE256 core scheduler.
package shake_sched_pkg;

  localparam int RATE_BITS = 1088;
  localparam int LEN_W     = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return len <= LEN_W'(RATE_BITS);
  endfunction

endpackage

// File: rtl/shake_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
module shake_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] idx;
  int             pos;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IDW'(pos);
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx;
      end
    end
  end

endmodule

// File: rtl/shake256_scheduler.sv
// Time-shares one SHAKE256 core between NREQ requesters, one job at a time.
// Define SHAKE_SCHED_TIMEOUT_EN to abort RUN after TIMEOUT cycles without squeezed.
//
// state | meaning
// IDLE  | grant winner combinationally, latch its block/length/id
// LOAD  | core held in reset one cycle with inputs stable
// RUN   | core released; wait for squeezed (ignored on the first cycle)
// RESP  | response held until rsp_ready
module shake256_scheduler
  import shake_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*RATE_BITS-1:0] req_message,
  input  logic [NREQ*LEN_W-1:0]     req_length,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [RATE_BITS-1:0]      rsp_hash,
  output logic                      rsp_err,
  output logic                      core_reset,
  output logic [RATE_BITS-1:0]      core_message,
  output logic [LEN_W-1:0]          core_length,
  input  logic                      core_busy,
  input  logic                      core_full,
  input  logic                      core_squeezed,
  input  logic [RATE_BITS-1:0]      core_hash
);

  localparam int             IDW         = $clog2(NREQ);
  localparam logic [15:0]    TIMEOUT_CNT = 16'(TIMEOUT);

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       winner;
  logic [NREQ-1:0]      grant;
  logic                 any;
  logic                 run_first;
  logic                 timed_out;
  logic [RATE_BITS-1:0] sel_message;
  logic [LEN_W-1:0]     sel_length;
  logic                 unused_status;

  // Core status is observed only; it never steers the sequencer.
  assign unused_status = ^{core_busy, core_full, TIMEOUT_CNT};

  shake_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  assign req_ready = (state == IDLE && reset) ? grant : '0;

  always_comb begin
    sel_message = '0;
    sel_length  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_message = req_message[i*RATE_BITS +: RATE_BITS];
        sel_length  = req_length[i*LEN_W +: LEN_W];
      end
    end
  end

`ifdef SHAKE_SCHED_TIMEOUT_EN
  logic [15:0] run_cnt;
  assign timed_out = (run_cnt + 16'd1) == TIMEOUT_CNT;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      run_first    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_hash     <= '0;
      rsp_err      <= 1'b0;
      core_reset   <= 1'b0;
      core_message <= '0;
      core_length  <= '0;
`ifdef SHAKE_SCHED_TIMEOUT_EN
      run_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            core_message <= sel_message;
            core_length  <= sel_length;
            rsp_id       <= winner;
            ptr          <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
            if (len_ok(sel_length)) begin
              state <= LOAD;
            end else begin
              // Oversized block: answer with an error, never release the core.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_hash  <= '0;
            end
          end
        end
        LOAD: begin
          core_reset <= 1'b1;
          run_first  <= 1'b1;
          state      <= RUN;
`ifdef SHAKE_SCHED_TIMEOUT_EN
          run_cnt    <= '0;
`endif
        end
        RUN: begin
          run_first <= 1'b0;
`ifdef SHAKE_SCHED_TIMEOUT_EN
          run_cnt   <= run_cnt + 16'd1;
`endif
          // squeezed may be stale from before the release on the first cycle.
          if (!run_first && core_squeezed) begin
            rsp_hash   <= core_hash;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            core_reset <= 1'b0;
            state      <= RESP;
          end else if (timed_out) begin
            rsp_hash   <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            core_reset <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_scheduler.sv
// Directed bench for shake256_scheduler with a simple squeeze-after-N core model.
module tb_shake256_scheduler;

  localparam int NREQ = 4;
  localparam int RB   = 1088;
  localparam int LW   = 11;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*RB-1:0] req_message;
  logic [NREQ*LW-1:0] req_length;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [RB-1:0]     rsp_hash;
  logic              rsp_err;
  logic              core_reset;
  logic [RB-1:0]     core_message;
  logic [LW-1:0]     core_length;
  logic              core_busy;
  logic              core_full;
  logic              core_squeezed;
  logic [RB-1:0]     core_hash;

  int checks = 0;
  int errors = 0;

  logic [RB-1:0] pat_a;
  logic [RB-1:0] pat_b;
  bit            sq_en;
  int            sq_delay;
  int            model_cnt;

  shake256_scheduler #(.NREQ(NREQ), .TIMEOUT(40)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_message   (req_message),
    .req_length    (req_length),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_hash      (rsp_hash),
    .rsp_err       (rsp_err),
    .core_reset    (core_reset),
    .core_message  (core_message),
    .core_length   (core_length),
    .core_busy     (core_busy),
    .core_full     (core_full),
    .core_squeezed (core_squeezed),
    .core_hash     (core_hash)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Core model: squeezed rises on the sq_delay-th cycle after release.
  initial begin
    model_cnt     = 0;
    core_squeezed = 1'b0;
    core_busy     = 1'b0;
    core_full     = 1'b0;
    forever begin
      @(negedge clock);
      if (core_reset === 1'b1) begin
        model_cnt     = model_cnt + 1;
        core_squeezed = sq_en && (model_cnt >= sq_delay);
        core_busy     = !core_squeezed;
      end else begin
        model_cnt     = 0;
        core_squeezed = 1'b0;
        core_busy     = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [RB-1:0] mk_msg(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    return {34{w}};
  endfunction

  task automatic set_req(input int i, input logic [RB-1:0] m, input logic [LW-1:0] l);
    req_message[i*RB +: RB] = m;
    req_length[i*LW +: LW]  = l;
  endtask

  // Starts on a negedge in IDLE; returns on the negedge after the transfer edge.
  task automatic grant_now(input logic [NREQ-1:0] v, output logic [NREQ-1:0] g);
    req_valid = v;
    #1;
    g = req_ready;
    @(negedge clock);
  endtask

  task automatic wait_rsp(input int max, output int cyc, output bit ok);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < max) begin
      @(negedge clock);
      cyc++;
    end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic accept;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset;
    req_valid = '0;
    rsp_ready = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    req_valid = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || rsp_hash !== '0) begin
      errors++; $display("FAIL reset_rsp: got valid=%b id=%0d err=%b want 0/0/0, hash zero", rsp_valid, rsp_id, rsp_err);
    end
    checks++;
    if (core_reset !== 1'b0 || core_message !== '0 || core_length !== '0) begin
      errors++; $display("FAIL reset_core: got core_reset=%b len=%0d want 0/0", core_reset, core_length);
    end
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single;
    logic [NREQ-1:0] g;
    int cyc;
    bit ok;
    core_hash = pat_a;
    sq_en     = 1'b1;
    sq_delay  = 25;
    set_req(1, '0, 11'd0);
    grant_now(4'b0010, g);
    req_valid = '0;
    checks++;
    if (g !== 4'b0010) begin
      errors++; $display("FAIL single_grant: got %b want 0010", g);
    end
    checks++;
    if (core_reset !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_load: got core_reset=%b rsp_valid=%b want 0/0", core_reset, rsp_valid);
    end
    @(negedge clock);
    checks++;
    if (core_reset !== 1'b1) begin
      errors++; $display("FAIL single_release: got core_reset=%b want 1", core_reset);
    end
    wait_rsp(100, cyc, ok);
    checks++;
    if (!ok || cyc != 25) begin
      errors++; $display("FAIL single_latency: got ok=%0d cycles=%0d want 1/25", ok, cyc);
    end
    checks++;
    if (rsp_id !== 2'd1 || rsp_err !== 1'b0 || core_reset !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got id=%0d err=%b core_reset=%b want 1/0/0", rsp_id, rsp_err, core_reset);
    end
    checks++;
    if (rsp_hash !== pat_a) begin
      errors++; $display("FAIL single_hash: got low %h want low %h", rsp_hash[127:0], pat_a[127:0]);
    end
    accept;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_accept: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_contention;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] v;
    int ids_a [2] = '{0, 2};
    int ids_b [5] = '{0, 1, 2, 3, 0};
    int cyc;
    bit ok;
    core_hash = pat_b;
    sq_delay  = 3;
    for (int i = 0; i < NREQ; i++) set_req(i, mk_msg(i), 11'(100 + i));
    apply_reset;
    v = 4'b0101;
    for (int j = 0; j < 2; j++) begin
      grant_now(v, g);
      v = v & ~g;
      req_valid = v;
      checks++;
      if (g !== 4'(1 << ids_a[j]) || core_message !== mk_msg(ids_a[j]) || core_length !== 11'(100 + ids_a[j])) begin
        errors++; $display("FAIL contention_0101_%0d: got grant=%b len=%0d want grant=%b len=%0d", j, g, core_length, 4'(1 << ids_a[j]), 100 + ids_a[j]);
      end
      wait_rsp(50, cyc, ok);
      checks++;
      if (!ok || rsp_id !== 2'(ids_a[j])) begin
        errors++; $display("FAIL contention_0101_rsp_%0d: got ok=%0d id=%0d want 1/%0d", j, ok, rsp_id, ids_a[j]);
      end
      accept;
    end
    apply_reset;
    for (int j = 0; j < 5; j++) begin
      grant_now(4'b1111, g);
      checks++;
      if (g !== 4'(1 << ids_b[j])) begin
        errors++; $display("FAIL contention_1111_%0d: got grant=%b want %b", j, g, 4'(1 << ids_b[j]));
      end
      wait_rsp(50, cyc, ok);
      checks++;
      if (!ok || rsp_id !== 2'(ids_b[j]) || rsp_hash !== pat_b) begin
        errors++; $display("FAIL contention_1111_rsp_%0d: got ok=%0d id=%0d want 1/%0d", j, ok, rsp_id, ids_b[j]);
      end
      accept;
    end
    req_valid = '0;
  endtask

  task automatic test_bad_length;
    logic [NREQ-1:0] g;
    bit saw_high;
    int cyc;
    bit ok;
    core_hash = pat_a;
    set_req(3, mk_msg(3), 11'd1089);
    grant_now(4'b1000, g);
    req_valid = '0;
    checks++;
    if (g !== 4'b1000 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL badlen_rsp: got grant=%b valid=%b err=%b id=%0d want 1000/1/1/3", g, rsp_valid, rsp_err, rsp_id);
    end
    checks++;
    if (rsp_hash !== '0) begin
      errors++; $display("FAIL badlen_hash: got low %h want zero", rsp_hash[127:0]);
    end
    saw_high = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (core_reset !== 1'b0) saw_high = 1'b1;
      @(negedge clock);
    end
    accept;
    if (core_reset !== 1'b0) saw_high = 1'b1;
    checks++;
    if (saw_high) begin
      errors++; $display("FAIL badlen_core_reset: got core released want held low");
    end
    // Exactly RATE_BITS is legal; squeezed asserted from the first RUN cycle.
    sq_delay = 1;
    set_req(0, mk_msg(7), 11'd1088);
    grant_now(4'b0001, g);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || core_length !== 11'd1088 || core_message !== mk_msg(7)) begin
      errors++; $display("FAIL maxlen_load: got rsp_valid=%b len=%0d want 0/1088", rsp_valid, core_length);
    end
    wait_rsp(50, cyc, ok);
    checks++;
    if (!ok || cyc != 3 || rsp_err !== 1'b0 || rsp_hash !== pat_a) begin
      errors++; $display("FAIL maxlen_rsp: got ok=%0d cycles=%0d err=%b want 1/3/0", ok, cyc, rsp_err);
    end
    accept;
  endtask

  task automatic test_backpressure;
    logic [NREQ-1:0] g;
    int cyc;
    bit ok;
    core_hash = pat_b;
    sq_delay  = 5;
    set_req(2, mk_msg(2), 11'd64);
    grant_now(4'b0100, g);
    req_valid = 4'b1011;
    wait_rsp(50, cyc, ok);
    checks++;
    if (g !== 4'b0100 || !ok) begin
      errors++; $display("FAIL bp_start: got grant=%b ok=%0d want 0100/1", g, ok);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_hash !== pat_b || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b id=%0d err=%b ready=%b want 1/2/0/0000", k, rsp_valid, rsp_id, rsp_err, req_ready);
      end
      @(negedge clock);
    end
    accept;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1000", rsp_valid, req_ready);
    end
    grant_now(4'b1011, g);
    req_valid = '0;
    wait_rsp(50, cyc, ok);
    checks++;
    if (!ok || rsp_id !== 2'd3) begin
      errors++; $display("FAIL bp_next: got ok=%0d id=%0d want 1/3", ok, rsp_id);
    end
    accept;
  endtask

`ifdef SHAKE_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    logic [NREQ-1:0] g;
    int n;
    int k;
    for (int pass = 0; pass < 2; pass++) begin
      core_hash = pat_a;
      sq_en     = (pass == 1);
      sq_delay  = 40;
      set_req(0, mk_msg(0), 11'd10);
      grant_now(4'b0001, g);
      req_valid = '0;
      n = 0;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 200) begin
        if (core_reset === 1'b1) n++;
        @(negedge clock);
        k++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || n != 40 || rsp_err !== (pass == 0)) begin
        errors++; $display("FAIL timeout_%0d: got valid=%b run_cycles=%0d err=%b want 1/40/%0d", pass, rsp_valid, n, rsp_err, pass == 0);
      end
      checks++;
      if (rsp_hash !== ((pass == 0) ? '0 : pat_a)) begin
        errors++; $display("FAIL timeout_hash_%0d: got low %h", pass, rsp_hash[127:0]);
      end
      accept;
    end
    sq_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_run;
    logic [NREQ-1:0] g;
    int n;
    int k;
    int cyc;
    bit ok;
    sq_en    = 1'b1;
    sq_delay = 200;
    set_req(1, mk_msg(1), 11'd8);
    grant_now(4'b0010, g);
    req_valid = '0;
    n = 0;
    k = 0;
    while (n < 10 && k < 50) begin
      @(negedge clock);
      if (core_reset === 1'b1) n++;
      k++;
    end
    req_valid = 4'b1111;
    reset     = 1'b0;
    #1;
    checks++;
    if (n != 10 || req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL midrun_rsp: got run=%0d ready=%b valid=%b id=%0d err=%b want 10/0000/0/0/0", n, req_ready, rsp_valid, rsp_id, rsp_err);
    end
    checks++;
    if (rsp_hash !== '0 || core_reset !== 1'b0 || core_message !== '0 || core_length !== '0) begin
      errors++; $display("FAIL midrun_core: got core_reset=%b len=%0d want 0/0, hashes zero", core_reset, core_length);
    end
    @(negedge clock);
    req_valid = '0;
    reset     = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midrun_norsp_%0d: got rsp_valid=%b want 0", j, rsp_valid);
      end
    end
    sq_delay = 2;
    grant_now(4'b1111, g);
    req_valid = '0;
    checks++;
    if (g !== 4'b0001) begin
      errors++; $display("FAIL midrun_pointer: got grant=%b want 0001", g);
    end
    wait_rsp(50, cyc, ok);
    checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL midrun_next: got ok=%0d id=%0d err=%b want 1/0/0", ok, rsp_id, rsp_err);
    end
    accept;
  endtask

  initial begin
    pat_a       = {17{64'hA5A5_0123_4567_89AB}};
    pat_b       = {34{32'hDEAD_BEEF}};
    sq_en       = 1'b1;
    sq_delay    = 25;
    core_hash   = '0;
    req_valid   = '0;
    req_message = '0;
    req_length  = '0;
    rsp_ready   = 1'b0;
    reset       = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_bad_length;
    test_backpressure;
`ifdef SHAKE_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shake256_scheduler.md
Name: shake256_scheduler

Overview:
- Shares one SHAKE256 core (1088-bit rate block, 11-bit bit-length, busy/full/squeezed/hash outputs) between NREQ requesters.
- Sequences each job: round-robin grant, latch block, hold core in reset, release it, wait for squeezed, capture hash, return it with the requester ID.
- Sits between the requester fabric and the single shared core instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max RUN cycles before abort (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request i present.
- req_ready  out  NREQ  one-hot accept; a transfer occurs when valid && ready.
- req_message  in  NREQ*1088  block for requester i, at slice [i*1088 +: 1088].
- req_length  in  NREQ*11  message length in bits for requester i, at slice [i*11 +: 11].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_id  out  $clog2(NREQ)  requester that owns the response.
- rsp_hash  out  1088  captured core hash.
- rsp_err  out  1  invalid length, or timeout.
- core_reset  out  1  active-low reset to the core; 1 lets it run.
- core_message  out  1088  latched block.
- core_length  out  11  latched length.
- core_busy  in  1  core status; monitored only.
- core_full  in  1  core status; monitored only.
- core_squeezed  in  1  hash valid.
- core_hash  in  1088  core output.

Behaviour:
- Reset (reset=0, any time, including mid-job):
  - state=IDLE, rr pointer=0, all latches cleared.
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_hash=0, rsp_err=0, core_reset=0, core_message=0, core_length=0.
  - An in-flight job is dropped with no response.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - req_ready[w]=1 combinationally for the winner w: the first requester with req_valid at or after the rr pointer, wrapping.
  - On transfer: latch message, length, id=w; pointer becomes (w+1) mod NREQ.
  - If length>1088: go to RESP with rsp_err=1, rsp_hash=0; the core is never released.
  - Otherwise go to LOAD.
- LOAD: core_reset=0 for exactly one cycle with core_message/core_length stable; then go to RUN.
- RUN:
  - core_reset=1; core_message/core_length held constant.
  - The first cycle in RUN ignores core_squeezed.
  - From the second RUN cycle, core_squeezed=1 captures core_hash into rsp_hash, sets rsp_err=0, and goes to RESP.
- RESP:
  - core_reset=0; rsp_valid=1.
  - rsp_id/rsp_hash/rsp_err are held stable until rsp_ready=1, then go to IDLE.
  - A new grant is possible in the IDLE cycle that follows.
- req_ready=0 in every state except IDLE; requests arriving meanwhile wait, with no loss or reordering per requester.
- Latency: transfer at edge T; LOAD during cycle T+1; RUN starts T+2; rsp_valid rises the cycle after the first qualifying squeezed sample.
- Simultaneous requests: exactly one is granted per IDLE visit. With NREQ requesters all valid, every requester is served within NREQ jobs.
- core_busy/core_full never change state.

Optional Feature:
- Macro: SHAKE_SCHED_TIMEOUT_EN.
- Enabled:
  - A 16-bit RUN-cycle counter, cleared on entry to RUN.
  - When it reaches TIMEOUT without squeezed, go to RESP with rsp_err=1, rsp_hash=0.
  - If squeezed and timeout occur in the same cycle, squeezed wins.
- Disabled: no counter; RUN waits indefinitely.

Decomposition:
- Package shake_sched_pkg:
  - RATE_BITS=1088, LEN_W=11.
  - state_t enum {IDLE, LOAD, RUN, RESP}.
  - Function len_ok(len) returning len<=RATE_BITS.
- Sub-module shake_rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded winner, any flag.

Test Plan:
- Single job: requester 1, length=0, message=0; core model squeezes 25 cycles after release and returns hash=pattern A -> core_reset low exactly 1 cycle; rsp_valid with rsp_id=1, rsp_hash=A, rsp_err=0.
- Contention: req_valid=4'b0101 with pointer=0 -> grants in order 0, 2; with 4'b1111 -> grant order 0,1,2,3,0.
- Bad length: requester 3, length=1089 -> rsp_err=1, rsp_hash=0; core_reset never goes high.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable, req_ready=0 throughout; then one accept and return to IDLE.
- Timeout (macro on, TIMEOUT=40, model never squeezes) -> rsp_err=1 after 40 RUN cycles. Squeezed coincident with cycle 40 -> rsp_err=0.
- Reset mid-RUN at cycle 10 -> all outputs at reset values; no response; the next job is granted from pointer 0.
